tmul_tile_sequencer: RTL and testbench

Controller that sequences the 8-level pipelined TMUL FMA array (8 lanes × 8 levels, 32-bit operands, 64-bit accumulators). It loads an 8-row B tile into a weight bank and streams A rows into the array. Per-level operand skew matches the pipeline depth. Array results are collected into a credit-protected result FIFO, so the non-stallable array never overflows. It sits between the command/operand interconnect and the TMUL array instance.

---
 rtl/tmul_pkg.sv | 28 ++
 rtl/tmul_res_fifo.sv | 49 ++++
 rtl/tmul_tile_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tmul_tile_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmul_pkg.sv
// Shared constants and types for the TMUL tile sequencer and its result FIFO.
package tmul_pkg;

    localparam int unsigned TMUL_N = 8;
    localparam int unsigned A_W    = 32;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned ID_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoadB,
        StIssue,
        StDrain
    } state_e;

    typedef struct packed {
        logic [TMUL_N-1:0][ACC_W-1:0] c;
        logic [ID_W-1:0]              id;
        logic                         last;
    } res_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            last;
    } token_t;

endpackage

// File: rtl/tmul_res_fifo.sv
// Synchronous result FIFO (power-of-two depth) with occupancy output.
module tmul_res_fifo
    import tmul_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  res_t                   push_data_i,
    input  logic                   pop_i,
    output res_t                   pop_data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] Full = (AW+1)'(DEPTH);

    res_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != Full) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign valid_o    = count_q != '0;
    assign count_o    = count_q;

endmodule

// File: rtl/tmul_tile_sequencer.sv
// Loads a B tile into the weight bank, streams skewed A rows into the TMUL array and
// collects array results into a credit-protected FIFO.
module tmul_tile_sequencer
    import tmul_pkg::*;
#(
    parameter int unsigned FMA_LAT   = 1,
    parameter int unsigned RES_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [7:0]                        cmd_rows,
    input  logic [ID_W-1:0]                   cmd_id,
    input  logic                              b_valid,
    output logic                              b_ready,
    input  logic [TMUL_N*A_W-1:0]             b_in,
    input  logic                              a_valid,
    output logic                              a_ready,
    input  logic [TMUL_N-1:0][A_W-1:0]        a_in,
    output logic [TMUL_N-1:0][A_W-1:0]        tmul_a,
    output logic [TMUL_N-1:0][TMUL_N*A_W-1:0] tmul_b,
    input  logic [TMUL_N-1:0][ACC_W-1:0]      tmul_c,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [TMUL_N-1:0][ACC_W-1:0]      res_c,
    output logic [ID_W-1:0]                   res_id,
    output logic                              res_last,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned TOK_D = TMUL_N * FMA_LAT + 1;
    localparam int unsigned CW    = $clog2(RES_DEPTH) + 1;

    state_e                            state_q, state_d;
    logic [7:0]                        rows_q, rows_d, row_cnt_q, row_cnt_d;
    logic [ID_W-1:0]                   id_q, id_d;
    logic [2:0]                        beat_q, beat_d;
    logic [CW-1:0]                     credits_q, credits_d, fifo_count, inflight;
    logic [TMUL_N-1:0][TMUL_N*A_W-1:0] b_bank_q;
    logic [TMUL_N-1:0][A_W-1:0]        a_in_q;
    token_t                            tok_q [TOK_D];
    logic                              b_hs, a_hs, push, pop, row_last, head_valid;
    res_t                              push_data, head;

    assign b_hs      = b_valid && b_ready;
    assign a_hs      = a_valid && a_ready;
    assign pop       = res_valid && res_ready;
    assign push      = tok_q[TOK_D-1].valid;
    assign row_last  = row_cnt_q == rows_q - 8'd1;
    assign inflight  = CW'(RES_DEPTH) - credits_q - fifo_count;
    assign credits_d = credits_q - CW'(a_hs) + CW'(pop);
    assign busy      = state_q != StIdle;

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        id_d      = id_q;
        beat_d    = beat_q;
        row_cnt_d = row_cnt_q;
        cmd_ready = 1'b0;
        b_ready   = 1'b0;
        a_ready   = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Held low while reset is asserted even though the state is already idle.
                cmd_ready = rst;
                if (cmd_valid && rst) begin
                    rows_d    = cmd_rows;
                    id_d      = cmd_id;
                    beat_d    = '0;
                    row_cnt_d = '0;
                    state_d   = StLoadB;
                end
            end
            StLoadB: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'(TMUL_N - 1)) state_d = (rows_q == '0) ? StDrain : StIssue;
                end
            end
            StIssue: begin
                a_ready = credits_q != '0;
                if (a_valid && a_ready) begin
                    row_cnt_d = row_cnt_q + 8'd1;
                    if (row_last) state_d = StDrain;
                end
            end
            StDrain: begin
                if (inflight == '0 && (rows_q == '0 || (pop && res_last))) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            rows_q    <= '0;
            id_q      <= '0;
            beat_q    <= '0;
            row_cnt_q <= '0;
            credits_q <= CW'(RES_DEPTH);
            b_bank_q  <= '0;
            a_in_q    <= '0;
            for (int i = 0; i < TOK_D; i++) tok_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            id_q      <= id_d;
            beat_q    <= beat_d;
            row_cnt_q <= row_cnt_d;
            credits_q <= credits_d;
            if (b_hs) b_bank_q[beat_q] <= b_in;
            // Idle slots feed zeros so the array never sees stale operands.
            a_in_q         <= a_hs ? a_in : '0;
            tok_q[0].valid <= a_hs;
            tok_q[0].id    <= id_q;
            tok_q[0].last  <= a_hs && row_last;
            for (int i = 1; i < TOK_D; i++) tok_q[i] <= tok_q[i-1];
        end
    end

    for (genvar k = 0; k < TMUL_N; k++) begin : g_skew
        localparam int D = k * FMA_LAT;
        if (D == 0) begin : g_direct
            assign tmul_a[k] = a_in_q[k];
        end else begin : g_line
            logic [A_W-1:0] line_q [D];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < D; i++) line_q[i] <= '0;
                end else begin
                    line_q[0] <= a_in_q[k];
                    for (int i = 1; i < D; i++) line_q[i] <= line_q[i-1];
                end
            end
            assign tmul_a[k] = line_q[D-1];
        end
    end

    assign tmul_b         = b_bank_q;
    assign push_data.c    = tmul_c;
    assign push_data.id   = tok_q[TOK_D-1].id;
    assign push_data.last = tok_q[TOK_D-1].last;

    tmul_res_fifo #(
        .DEPTH(RES_DEPTH)
    ) u_res_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .pop_data_o (head),
        .valid_o    (head_valid),
        .count_o    (fifo_count)
    );

    assign res_valid = head_valid;
    assign res_c     = head_valid ? head.c : '0;
    assign res_id    = head_valid ? head.id : '0;
    assign res_last  = head_valid && head.last;

endmodule

// File: tb/tb_tmul_tile_sequencer.sv
// Directed bench for tmul_tile_sequencer with a behavioural 8-level FMA array model.
module tb_tmul_tile_sequencer;
    import tmul_pkg::*;

    logic                 clk, rst;
    logic                 cmd_valid, cmd_ready, b_valid, b_ready, a_valid, a_ready;
    logic [7:0]           cmd_rows;
    logic [3:0]           cmd_id, res_id;
    logic [255:0]         b_in;
    logic [7:0][31:0]     a_in, tmul_a;
    logic [7:0][255:0]    tmul_b;
    logic [7:0][63:0]     tmul_c, res_c;
    logic                 res_valid, res_ready, res_last, busy, done;

    tmul_tile_sequencer #(.FMA_LAT(1), .RES_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rows(cmd_rows), .cmd_id(cmd_id), .b_valid(b_valid), .b_ready(b_ready),
        .b_in(b_in), .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in), .tmul_a(tmul_a),
        .tmul_b(tmul_b), .tmul_c(tmul_c), .res_valid(res_valid), .res_ready(res_ready),
        .res_c(res_c), .res_id(res_id), .res_last(res_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: level k adds a[k] * B[k][lane] to the partial sum from level k-1.
    logic [7:0][63:0] psum_q [8];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) psum_q[k] <= '0;
        end else begin
            for (int j = 0; j < 8; j++) begin
                psum_q[0][j] <= 64'(tmul_a[0]) * 64'(tmul_b[0][j*32 +: 32]);
                for (int k = 1; k < 8; k++)
                    psum_q[k][j] <= psum_q[k-1][j] + 64'(tmul_a[k]) * 64'(tmul_b[k][j*32 +: 32]);
            end
        end
    end
    assign tmul_c = psum_q[7];

    typedef struct {
        logic [7:0][63:0] c;
        logic [3:0]       id;
        logic             last;
        int               cyc;
    } obs_t;

    typedef struct {
        logic [3:0]       id;
        logic [7:0]       rows;
        int               bmode;
        int               amode;
        logic [31:0]      aval;
        logic [7:0][63:0] exp;
        logic [63:0]      step;
    } vec_t;

    int               checks = 0, failures = 0;
    int               cyc = 0, done_cnt = 0, done_cyc = 0, first_acc = -1;
    logic             ready_at_done;
    logic [7:0][31:0] a_snap;
    obs_t             res_q [$];
    vec_t             vecs [7];

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #2;
        if (res_valid && res_ready) res_q.push_back('{c: res_c, id: res_id, last: res_last, cyc: cyc});
        if (done) begin
            done_cnt++;
            done_cyc      = cyc;
            ready_at_done = cmd_ready;
        end
        if (a_valid && a_ready && first_acc < 0) first_acc = cyc;
        for (int k = 0; k < 8; k++) if (first_acc >= 0 && cyc == first_acc + 1 + k) a_snap[k] = tmul_a[k];
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] brow(input int mode, input int k);
        logic [255:0] r = '0;
        for (int j = 0; j < 8; j++)
            r[j*32 +: 32] = (mode == 0) ? ((j == k) ? 32'd1 : 32'd0) : (mode == 1) ? 32'd2 : 32'(k + 1);
        return r;
    endfunction

    function automatic logic [7:0][31:0] arow(input int mode, input logic [31:0] aval, input int r);
        logic [7:0][31:0] a;
        for (int k = 0; k < 8; k++) a[k] = (mode == 0) ? aval : (mode == 1) ? 32'(k + 1) : aval + 32'(r);
        return a;
    endfunction

    function automatic vec_t mk(input logic [3:0] id, input logic [7:0] rows, input int bmode,
                                input int amode, input logic [31:0] aval,
                                input logic [7:0][63:0] exp, input logic [63:0] step);
        vec_t v;
        v.id = id; v.rows = rows; v.bmode = bmode; v.amode = amode;
        v.aval = aval; v.exp = exp; v.step = step;
        return v;
    endfunction

    task automatic do_cmd(input logic [3:0] id, input logic [7:0] rows, input bit keep);
        int n = 0;
        cmd_valid = 1'b1; cmd_id = id; cmd_rows = rows;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept_in_time", 512'(n < 50), 512'(1));
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic load_b(input int mode);
        int stall = 0;
        for (int k = 0; k < 8; k++) begin
            b_valid = 1'b1;
            b_in    = brow(mode, k);
            while (!b_ready && stall < 50) begin @(negedge clk); stall++; end
            @(negedge clk);
        end
        b_valid = 1'b0;
        chk("b_load_no_stall", 512'(stall), 512'(0));
    endtask

    task automatic send_rows(input int n, input int first, input int amode, input logic [31:0] aval,
                             input int budget, output int sent, output int used);
        logic hs;
        sent = 0; used = 0;
        while (sent < n && used < budget) begin
            a_valid = 1'b1;
            a_in    = arow(amode, aval, first + sent);
            hs      = a_ready;
            @(negedge clk);
            used++;
            if (hs) sent++;
        end
        a_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int start = done_cnt;
        while (done_cnt == start && n < budget) begin @(negedge clk); n++; end
        chk("done_in_time", 512'(n < budget), 512'(1));
    endtask

    task automatic run_vec(input int i);
        vec_t             v = vecs[i];
        int               sent, used, d0;
        logic [7:0][63:0] e;
        res_q.delete();
        first_acc = -1;
        d0 = done_cnt;
        do_cmd(v.id, v.rows, 1'b0);
        load_b(v.bmode);
        send_rows(int'(v.rows), 0, v.amode, v.aval, 40, sent, used);
        chk($sformatf("v%0d_rows_sent", i), 512'(sent), 512'(v.rows));
        chk($sformatf("v%0d_rows_b2b", i), 512'(used), 512'(v.rows));
        wait_done(100);
        chk($sformatf("v%0d_busy_after_done", i), 512'(busy), 512'(0));
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_done_once", i), 512'(done_cnt - d0), 512'(1));
        chk($sformatf("v%0d_result_count", i), 512'(res_q.size()), 512'(v.rows));
        for (int r = 0; r < int'(v.rows) && r < res_q.size(); r++) begin
            for (int j = 0; j < 8; j++) e[j] = v.exp[j] + 64'(r) * v.step;
            chk($sformatf("v%0d_r%0d_c", i, r), 512'(res_q[r].c), 512'(e));
            chk($sformatf("v%0d_r%0d_id", i, r), 512'(res_q[r].id), 512'(v.id));
            chk($sformatf("v%0d_r%0d_last", i, r), 512'(res_q[r].last), 512'(r == int'(v.rows) - 1));
            if (r > 0) chk($sformatf("v%0d_r%0d_cycle", i, r), 512'(res_q[r].cyc - res_q[0].cyc), 512'(r));
        end
        if (i == 0 && res_q.size() > 0) begin
            chk("v0_res_latency", 512'(res_q[0].cyc - first_acc), 512'(10));
            chk("v0_skew_a", 512'(a_snap), 512'({32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int sent, used, d0, n, viol;
        rst = 1'b0; cmd_valid = 1'b0; cmd_rows = '0; cmd_id = '0; b_valid = 1'b0; b_in = '0;
        a_valid = 1'b0; a_in = '0; res_ready = 1'b1;

        vecs[0] = mk(4'h3, 8'd1, 0, 1, 32'd0,
                     {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1}, 64'd0);
        vecs[1] = mk(4'h5, 8'd4, 1, 0, 32'd3, {8{64'd48}}, 64'd0);
        vecs[2] = mk(4'h9, 8'd2, 2, 0, 32'd1, {8{64'd36}}, 64'd0);
        vecs[3] = mk(4'hf, 8'd1, 0, 0, 32'hffff_ffff, {8{64'h0000_0000_ffff_ffff}}, 64'd0);
        vecs[4] = mk(4'h1, 8'd1, 1, 0, 32'hffff_ffff, {8{64'h0000_000f_ffff_fff0}}, 64'd0);
        vecs[5] = mk(4'h2, 8'd0, 0, 0, 32'd0, {8{64'd0}}, 64'd0);
        vecs[6] = mk(4'h6, 8'd3, 2, 2, 32'd10, {8{64'd360}}, 64'd36);

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 512'(cmd_ready), 512'(0));
        chk("rst_ready_valid", 512'({b_ready, a_ready, res_valid, res_last, busy, done}), 512'(0));
        chk("rst_tmul_a", 512'(tmul_a), 512'(0));
        chk("rst_tmul_b", 512'(|tmul_b), 512'(0));
        chk("rst_res_c_id", 512'({res_c, res_id}), 512'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 512'(cmd_ready), 512'(1));

        for (int i = 0; i < 7; i++) run_vec(i);

        // Backpressure: 20 rows offered with the result port stalled.
        res_q.delete();
        d0 = done_cnt;
        res_ready = 1'b0;
        do_cmd(4'h7, 8'd20, 1'b0);
        load_b(0);
        send_rows(20, 0, 2, 32'd100, 40, sent, used);
        chk("bp_rows_accepted", 512'(sent), 512'(8));
        chk("bp_a_ready_low", 512'(a_ready), 512'(0));
        chk("bp_res_valid", 512'(res_valid), 512'(1));
        res_ready = 1'b1;
        send_rows(12, 8, 2, 32'd100, 80, sent, used);
        chk("bp_rest_accepted", 512'(sent), 512'(12));
        wait_done(100);
        repeat (3) @(negedge clk);
        chk("bp_result_count", 512'(res_q.size()), 512'(20));
        chk("bp_done_once", 512'(done_cnt - d0), 512'(1));
        for (int r = 0; r < 20 && r < res_q.size(); r++) begin
            chk($sformatf("bp_r%0d_c", r), 512'(res_q[r].c), 512'({8{64'(100 + r)}}));
            chk($sformatf("bp_r%0d_id_last", r), 512'({res_q[r].id, res_q[r].last}),
                512'({4'h7, r == 19}));
        end

        // Reset with three rows in flight.
        res_q.delete();
        d0 = done_cnt;
        do_cmd(4'h4, 8'd3, 1'b0);
        load_b(0);
        send_rows(3, 0, 1, 32'd0, 10, sent, used);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 512'(cmd_ready), 512'(0));
        chk("mid_rst_flags", 512'({b_ready, a_ready, res_valid, res_last, busy, done}), 512'(0));
        chk("mid_rst_tmul_a", 512'(tmul_a), 512'(0));
        chk("mid_rst_tmul_b", 512'(|tmul_b), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_results", 512'(res_q.size()), 512'(0));
        chk("mid_rst_no_done", 512'(done_cnt - d0), 512'(0));
        run_vec(0);

        // cmd_valid held high while busy; second command queued behind the first.
        res_q.delete();
        d0 = done_cnt;
        viol = 0;
        n = 0;
        do_cmd(4'ha, 8'd1, 1'b1);
        cmd_id = 4'hb;
        cmd_rows = 8'd1;
        load_b(0);
        send_rows(1, 0, 1, 32'd0, 10, sent, used);
        while (done_cnt == d0 && n < 100) begin
            if (busy && cmd_ready) viol++;
            @(negedge clk);
            n++;
        end
        chk("hold_done_in_time", 512'(n < 100), 512'(1));
        chk("hold_ready_low_busy", 512'(viol), 512'(0));
        chk("hold_ready_at_done", 512'(ready_at_done), 512'(0));
        chk("hold_ready_after_done", 512'({cmd_ready, cyc == done_cyc + 1}), 512'(2'b11));
        @(negedge clk);
        cmd_valid = 1'b0;
        load_b(1);
        send_rows(1, 0, 0, 32'd3, 10, sent, used);
        wait_done(100);
        repeat (3) @(negedge clk);
        chk("hold_result_count", 512'(res_q.size()), 512'(2));
        if (res_q.size() == 2) begin
            chk("hold_first_c", 512'(res_q[0].c),
                512'({64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1}));
            chk("hold_first_id", 512'(res_q[0].id), 512'(4'ha));
            chk("hold_second_c", 512'(res_q[1].c), 512'({8{64'd48}}));
            chk("hold_second_id", 512'(res_q[1].id), 512'(4'hb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
